time_pps_stamp_wr: RTL

//  Timestamp producer placed upstream of the time-word FIFO whose read side drives the

---
 rtl/time_pps_stamp_wr.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/time_pps_stamp_wr.sv
// Timestamp producer for the time-word FIFO.
// Keeps a 32-bit seconds counter disciplined by an external 1PPS and measures the
// length of every second in sclk ticks. Each second produces one {sec, period} word.
// When PPS is lost the block free-runs in holdover on the nominal tick count.
module time_pps_stamp_wr #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned PPS_TOL = 1000
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        pps_in,
  input  logic        time_set_en,
  input  logic [31:0] time_set_sec,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [63:0] fifo_wr_data,
  output logic        holdover,
  output logic [15:0] drop_cnt
);

  localparam logic [31:0] TICKS_NOM  = 32'(CLK_HZ);
  localparam logic [31:0] TICKS_LO   = 32'(CLK_HZ - PPS_TOL);
  localparam logic [31:0] TICKS_HI   = 32'(CLK_HZ + PPS_TOL);
  localparam logic [31:0] TICKS_HALF = 32'(CLK_HZ / 2);

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_LOCK   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_s1, r_s2, r_s3;
  logic        w_pps_rise;
  logic [31:0] r_tick_cnt;
  logic [31:0] w_tick_nxt;
  logic [31:0] r_sec;
  logic [31:0] w_sec_nxt;
  logic [31:0] w_period;
  logic [31:0] r_set_val;
  logic        r_set_pending;
  logic        w_event;
  logic        w_realign;
  logic        w_first;
  logic        r_wr_en;
  logic [63:0] r_wr_data;
  logic        r_holdover;
  logic [15:0] r_drop_cnt;

  assign w_pps_rise = r_s2 & ~r_s3;
  assign w_tick_nxt = r_tick_cnt + 32'd1;
  // The event that leaves UNLOCK has no meaningful previous second to measure.
  assign w_period   = w_first ? 32'd0 : w_tick_nxt;
  assign w_sec_nxt  = r_set_pending ? r_set_val : (r_sec + 32'd1);

  // Three-flop synchroniser for the asynchronous PPS input.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pps_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Lock state register.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_UNLOCK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Decide second events, realigns and lock transitions from PPS and the tick count.
  always_comb begin
    w_state_nxt = r_state;
    w_event     = 1'b0;
    w_realign   = 1'b0;
    w_first     = 1'b0;
    case (r_state)
      ST_UNLOCK: begin
        if (w_pps_rise) begin
          w_event     = 1'b1;
          w_first     = 1'b1;
          w_state_nxt = ST_LOCK;
        end else begin
          w_state_nxt = ST_UNLOCK;
        end
      end
      ST_LOCK: begin
        // An early pulse below the window is a glitch and leaves everything untouched.
        if (w_pps_rise && (w_tick_nxt >= TICKS_LO) && (w_tick_nxt <= TICKS_HI)) begin
          w_event = 1'b1;
        end else if (w_tick_nxt == TICKS_HI) begin
          w_event     = 1'b1;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_LOCK;
        end
      end
      ST_HOLD: begin
        // A returning PPS always relocks; late enough it also marks the second.
        if (w_pps_rise) begin
          if (w_tick_nxt >= TICKS_HALF) begin
            w_event = 1'b1;
          end else begin
            w_realign = 1'b1;
          end
          w_state_nxt = ST_LOCK;
        end else if (w_tick_nxt == TICKS_NOM) begin
          w_event = 1'b1;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_UNLOCK;
      end
    endcase
  end

  // Tick counter: idle while unlocked, restarts at each second mark or realign.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= 32'd0;
    end else if ((r_state == ST_UNLOCK) || w_event || w_realign) begin
      r_tick_cnt <= 32'd0;
    end else begin
      r_tick_cnt <= w_tick_nxt;
    end
  end

  // Seconds counter advances (or loads a pending set value) on every second event.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec <= 32'd0;
    end else if (w_event) begin
      r_sec <= w_sec_nxt;
    end
  end

  // Time-set capture; a new request on an event cycle waits for the following event.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_val     <= 32'd0;
      r_set_pending <= 1'b0;
    end else if (time_set_en) begin
      r_set_val     <= time_set_sec;
      r_set_pending <= 1'b1;
    end else if (w_event) begin
      r_set_pending <= 1'b0;
    end
  end

  // Registered FIFO write; data holds its last value between writes.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= 64'd0;
    end else if (w_event && !fifo_full) begin
      r_wr_en   <= 1'b1;
      r_wr_data <= {w_sec_nxt, w_period};
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  // Saturating count of words lost to a full FIFO.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= 16'd0;
    end else if (w_event && fifo_full && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Holdover flag tracks the state the FSM is entering.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_holdover <= 1'b0;
    end else begin
      r_holdover <= (w_state_nxt == ST_HOLD);
    end
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_wr_data = r_wr_data;
  assign holdover     = r_holdover;
  assign drop_cnt     = r_drop_cnt;

endmodule
